// File: rtl/spi_reg_master.sv
// SPI register master (CPOL=0, CPHA=1, MSB first). A write frame is 16 SCLK periods and a read frame is 24; done pulses on entering GAP.
// There is no backpressure: start is taken only in IDLE. Defining SPI_REG_MASTER_ABORT_EN adds the abort/aborted ports.
module spi_reg_master #(
  parameter int HALF_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs
`ifdef SPI_REG_MASTER_ABORT_EN
  ,
  input  logic       abort,
  output logic       aborted
`endif
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(HALF_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic        rw_q;
  logic [15:0] tx_q;
  logic [7:0]  rx_q;
  logic        div_last;
  logic        last_bit;
  logic        abort_hit;

  assign div_last = (div_cnt == DIV_LAST);
  assign last_bit = (bit_cnt == (rw_q ? 5'd23 : 5'd15));

`ifdef SPI_REG_MASTER_ABORT_EN
  assign abort_hit = abort && (state_q == SETUP || state_q == SHIFT_HI || state_q == SHIFT_LO);
`else
  assign abort_hit = 1'b0;
`endif

  assign cs   = (state_q == IDLE) || (state_q == GAP);
  assign sclk = (state_q == SHIFT_HI);
  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = SETUP;
      SETUP:    if (div_last) state_d = SHIFT_HI;
      SHIFT_HI: if (div_last) state_d = SHIFT_LO;
      SHIFT_LO: if (div_last) state_d = last_bit ? GAP : SHIFT_HI;
      GAP:      if (div_last) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (abort_hit) state_d = GAP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      rw_q    <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata   <= '0;
      mosi    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_cnt <= (state_d != state_q || state_q == IDLE) ? 8'd0 : div_cnt + 8'd1;
      done    <= (state_q == SHIFT_LO) && (state_d == GAP) && !abort_hit;

      if (state_q == IDLE && start) begin
        rw_q    <= rw;
        // Read frames send zeros after the command byte, so wdata is not loaded.
        tx_q    <= {rw, addr, rw ? 8'h00 : wdata};
        bit_cnt <= '0;
        rx_q    <= '0;
      end

      if (state_d == SHIFT_HI && state_q != SHIFT_HI) begin
        mosi <= tx_q[15];
        tx_q <= {tx_q[14:0], 1'b0};
      end else if (state_d == GAP || state_d == IDLE) begin
        mosi <= 1'b0;
      end

      // miso is sampled on the edge where sclk falls.
      if (state_q == SHIFT_HI && state_d == SHIFT_LO) begin
        rx_q <= {rx_q[6:0], miso};
        if (rw_q && bit_cnt == 5'd23) rdata <= {rx_q[6:0], miso};
      end

      if (state_q == SHIFT_LO && div_last) bit_cnt <= bit_cnt + 5'd1;
    end
  end

`ifdef SPI_REG_MASTER_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst) aborted <= 1'b0;
    else     aborted <= abort_hit;
  end
`endif

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master (HALF_DIV=4): write, read, busy-ignore, back-to-back, reset and optional abort.
module tb_spi_reg_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy, done, sclk, mosi, cs;
  logic       miso;
  logic [7:0] rdata;
`ifdef SPI_REG_MASTER_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int checks = 0;
  int errors = 0;

  spi_reg_master #(.HALF_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .sclk(sclk), .mosi(mosi),
    .miso(miso), .cs(cs)
`ifdef SPI_REG_MASTER_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  always #5 clk = ~clk;

  // Slave model and line monitor, sampled on the falling clk edge.
  logic [23:0] mosi_cap;
  logic [7:0]  slave_byte;
  int          rise_cnt, cs_low, done_cnt;
  logic        prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (sclk && !prev_sclk) begin
      mosi_cap = {mosi_cap[22:0], mosi};
      miso     = (rise_cnt >= 16 && rise_cnt < 24) ? slave_byte[23 - rise_cnt] : 1'b0;
      rise_cnt = rise_cnt + 1;
    end
    prev_sclk = sclk;
    if (!cs)  cs_low   = cs_low + 1;
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns just after the accepting rising edge.
  task automatic start_txn(input logic r, input logic [6:0] a, input logic [7:0] d);
    start = 1'b1; rw = r; addr = a; wdata = d;
    @(posedge clk); #1;
    start = 1'b0;
    mosi_cap = '0; rise_cnt = 0; cs_low = 0; done_cnt = 0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 1000) begin @(negedge clk); n++; end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 1000) begin @(negedge clk); n++; end
  endtask

  task automatic wait_rise(input int target, input string tag);
    int n = 0;
    while (rise_cnt < target && n < 1000) begin @(negedge clk); n++; end
    if (rise_cnt < target) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0; miso = 1'b0;
    slave_byte = 8'h3C; mosi_cap = '0; rise_cnt = 0; cs_low = 0; done_cnt = 0;
`ifdef SPI_REG_MASTER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", cs, 1); check("rst_sclk", sclk, 0); check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_rdata", rdata, 8'h00);
`ifdef SPI_REG_MASTER_ABORT_EN
    check("rst_aborted", aborted, 0);
`endif
    rst = 1'b0;

    // Write 0x05 <- 0xA5
    @(negedge clk);
    start_txn(1'b0, 7'h05, 8'hA5);
    check("wr_busy", busy, 1); check("wr_cs", cs, 0);
    wait_done("wr");
    check("wr_cs_at_done", cs, 1);
    wait_idle(n);
    check("wr_busy_tail", n, 4);
    check("wr_mosi", mosi_cap[15:0], 16'h05A5);
    check("wr_rises", rise_cnt, 16);
    check("wr_cs_low", cs_low, 132);
    check("wr_done_cnt", done_cnt, 1);
    check("wr_rdata", rdata, 8'h00);

    // Read 0x02, slave returns 0x3C
    @(negedge clk);
    start_txn(1'b1, 7'h02, 8'hFF);
    wait_done("rd");
    check("rd_rdata_at_done", rdata, 8'h3C);
    wait_idle(n);
    check("rd_busy_tail", n, 4);
    check("rd_mosi", mosi_cap, 24'h820000);
    check("rd_rises", rise_cnt, 24);
    check("rd_cs_low", cs_low, 196);
    check("rd_done_cnt", done_cnt, 1);

    // Busy: start during SHIFT_HI and during GAP must be ignored
    @(negedge clk);
    start_txn(1'b0, 7'h11, 8'h5A);
    n = 0;
    while (!sclk && n < 100) begin @(negedge clk); n++; end
    start = 1'b1; rw = 1'b1; addr = 7'h7F; wdata = 8'hFF;
    @(negedge clk); start = 1'b0;
    wait_done("busy");
    start = 1'b1; rw = 1'b1; addr = 7'h40; wdata = 8'h00;
    @(negedge clk); start = 1'b0;
    wait_idle(n);
    check("busy_mosi", mosi_cap[15:0], 16'h115A);
    check("busy_cs_low", cs_low, 132);
    repeat (3) @(negedge clk);
    check("busy_no_restart", busy, 0);
    check("busy_done_cnt", done_cnt, 1);
    check("busy_rdata", rdata, 8'h3C);

    // Back-to-back: start in the first IDLE cycle after GAP
    start_txn(1'b0, 7'h33, 8'hC3);
    wait_done("b2b_a");
    wait_idle(n);
    start_txn(1'b0, 7'h44, 8'h12);
    check("b2b_accept", busy, 1);
    wait_done("b2b_b");
    wait_idle(n);
    check("b2b_mosi", mosi_cap[15:0], 16'h4412);

    // Reset at bit 10 of a read
    @(negedge clk);
    start_txn(1'b1, 7'h02, 8'h00);
    wait_rise(11, "rst_mid");
    rst = 1'b1;
    @(posedge clk); #1;
    check("rmid_cs", cs, 1); check("rmid_sclk", sclk, 0); check("rmid_busy", busy, 0);
    check("rmid_rdata", rdata, 8'h00); check("rmid_mosi", mosi, 0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("rmid_done_cnt", done_cnt, 0);
    check("rmid_rdata_later", rdata, 8'h00);

`ifdef SPI_REG_MASTER_ABORT_EN
    // Abort at bit 5 of a write, then a normal write
    start_txn(1'b0, 7'h05, 8'hA5);
    wait_rise(6, "abt");
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abt_cs", cs, 1); check("abt_sclk", sclk, 0); check("abt_mosi", mosi, 0);
    check("abt_pulse", aborted, 1); check("abt_busy", busy, 1);
    @(posedge clk); #1;
    check("abt_pulse_end", aborted, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abt_gap_ignored", aborted, 0);
    wait_idle(n);
    check("abt_done_cnt", done_cnt, 0);
    check("abt_rdata", rdata, 8'h00);
    start_txn(1'b0, 7'h2B, 8'h7E);
    wait_done("abt_next");
    wait_idle(n);
    check("abt_next_mosi", mosi_cap[15:0], 16'h2B7E);
    check("abt_next_done", done_cnt, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
